// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic mesh result path.
//   collector_state_t : result collector FSM states
//   idx_w(n)          : index width for an n-entry dimension, never below 1 bit
package systolic_pkg;

    typedef enum logic [1:0] {
        COL_IDLE    = 2'd0,
        COL_COLLECT = 2'd1,
        COL_STREAM  = 2'd2
    } collector_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_buffer.sv
// NxN result register file.
//   clk_i       : clock
//   wr_en_i     : per-row write enable (N row write ports)
//   wr_col_i    : column address shared by all row write ports
//   wr_data_i   : N words packed, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   rd_row_i    : read row address
//   rd_col_i    : read column address
//   rd_data_o   : combinational read data
// Contents are not reset; the collector always fills every entry before reading.
module result_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IW        = idx_w(N)
) (
    input  logic                    clk_i,
    input  logic [N-1:0]            wr_en_i,
    input  logic [IW-1:0]           wr_col_i,
    input  logic [N*DATA_WIDTH-1:0] wr_data_i,
    input  logic [IW-1:0]           rd_row_i,
    input  logic [IW-1:0]           rd_col_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [N][N];

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < N; r++) begin
            if (wr_en_i[r]) begin
                mem_q[r][wr_col_i] <= wr_data_i[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_data_o = mem_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/mesh_result_collector.sv
// Collects accumulator results drained column by column from the mesh east edge into an
// NxN buffer, then streams the matrix row-major over valid/ready. One matrix per start.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   start_i        : arm pulse, honoured only when idle
//   east_i         : one word per mesh row, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   east_valid_i   : per-row valid for east_i
//   out_data_o     : streamed result word, with its out_row_o / out_col_o indices
//   out_valid_o    : result word valid; out_ready_i : consumer ready
//   out_last_o     : marks element [N-1][N-1]
//   busy_o         : collecting or streaming
//   done_o         : one-cycle pulse after the final handshake
//   overflow_o     : sticky, a row delivered twice within one column
module mesh_result_collector
    import systolic_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IW        = idx_w(N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [N*DATA_WIDTH-1:0] east_i,
    input  logic [N-1:0]            east_valid_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [IW-1:0]           out_row_o,
    output logic [IW-1:0]           out_col_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o
);

    localparam logic [IW-1:0] MaxIdx = IW'(N - 1);
    localparam logic [IW-1:0] One    = IW'(1);

    collector_state_t state_q, state_d;
    logic [N-1:0]     got_q, got_d, wr_en;
    logic [IW-1:0]    col_ptr_q, col_ptr_d, wr_col;
    logic [IW-1:0]    rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]    out_row_q, out_row_d, out_col_q, out_col_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic             done_q, done_d, overflow_q, overflow_d;
    logic             complete, handshake;

    result_buffer #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_col_i  (wr_col),
        .wr_data_i (east_i),
        .rd_row_i  (rd_row_q),
        .rd_col_i  (rd_col_q),
        .rd_data_o (rd_data)
    );

    assign complete  = &got_q;
    assign handshake = out_valid_q & out_ready_i;

    always_comb begin
        state_d     = state_q;
        got_d       = got_q;
        col_ptr_d   = col_ptr_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        wr_en       = '0;
        wr_col      = col_ptr_q;

        unique case (state_q)
            COL_IDLE: begin
                if (start_i) begin
                    state_d    = COL_COLLECT;
                    got_d      = '0;
                    col_ptr_d  = '0;
                    rd_row_d   = '0;
                    rd_col_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            COL_COLLECT: begin
                if (complete) begin
                    // Completion cycle: got[] is being cleared, so arrivals belong to the
                    // next column and can never be duplicates.
                    wr_col = col_ptr_q + One;
                    if (col_ptr_q == MaxIdx) begin
                        state_d   = COL_STREAM;
                        got_d     = '0;
                        col_ptr_d = '0;
                    end else begin
                        wr_en     = east_valid_i;
                        got_d     = east_valid_i;
                        col_ptr_d = col_ptr_q + One;
                    end
                end else begin
                    wr_en = east_valid_i & ~got_q;
                    got_d = got_q | east_valid_i;
                    if (|(east_valid_i & got_q)) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            COL_STREAM: begin
                if (handshake && out_last_q) begin
                    state_d     = COL_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = '0;
                    out_row_d   = '0;
                    out_col_d   = '0;
                    done_d      = 1'b1;
                end else if (!out_valid_q || handshake) begin
                    // Output slot empty (first word) or being drained: load next element.
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_row_d   = rd_row_q;
                    out_col_d   = rd_col_q;
                    out_last_d  = (rd_row_q == MaxIdx) && (rd_col_q == MaxIdx);
                    if (rd_col_q == MaxIdx) begin
                        rd_col_d = '0;
                        rd_row_d = rd_row_q + One;
                    end else begin
                        rd_col_d = rd_col_q + One;
                    end
                end
            end
            default: state_d = COL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COL_IDLE;
            got_q       <= '0;
            col_ptr_q   <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            got_q       <= got_d;
            col_ptr_q   <= col_ptr_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_row_o   = out_row_q;
    assign out_col_o   = out_col_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q != COL_IDLE);

endmodule

// File: tb/tb_mesh_result_collector.sv
module tb_mesh_result_collector;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [2*DW-1:0] east_i;
    logic [1:0]    east_valid_i;
    logic [DW-1:0] out_data_o;
    logic [0:0]    out_row_o;
    logic [0:0]    out_col_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    int checks   = 0;
    int failures = 0;

    mesh_result_collector #(
        .N          (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .east_i       (east_i),
        .east_valid_i (east_valid_i),
        .out_data_o   (out_data_o),
        .out_row_o    (out_row_o),
        .out_col_o    (out_col_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of east-side input (called at a negedge), then idle the bus.
    task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        east_valid_i = v;
        east_i       = {d1, d0};
        @(negedge clk_i);
        east_valid_i = 2'b00;
        east_i       = '0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("valid_wait", {31'd0, out_valid_o}, 32'd1);
    endtask

    // Consume the 2x2 matrix; stall ready for stall_n cycles when word stall_idx appears.
    task automatic expect_stream(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3,
                                 input int stall_idx, input int stall_n);
        logic [31:0] exp_w [4];
        exp_w = '{e0, e1, e2, e3};
        out_ready_i = 1'b1;
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            if (i == stall_idx) begin
                out_ready_i = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk_i);
                    check_eq({tag, "_hold_data"}, out_data_o, exp_w[i]);
                    check_eq({tag, "_hold_rc"}, {30'd0, out_row_o, out_col_o}, i);
                    check_eq({tag, "_hold_valid"}, {31'd0, out_valid_o}, 32'd1);
                end
                out_ready_i = 1'b1;
            end
            check_eq({tag, "_data"}, out_data_o, exp_w[i]);
            check_eq({tag, "_rc"}, {30'd0, out_row_o, out_col_o}, i);
            check_eq({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
            check_eq({tag, "_last"}, {31'd0, out_last_o}, (i == 3) ? 32'd1 : 32'd0);
            @(negedge clk_i);
        end
        check_eq({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check_eq({tag, "_valid_off"}, {31'd0, out_valid_o}, 32'd0);
        @(negedge clk_i);
        check_eq({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        east_i = '0;
        east_valid_i = 2'b00;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_data", out_data_o, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Test 2: both rows per column, full ready.
        do_start();
        check_eq("t2_busy", {31'd0, busy_o}, 32'd1);
        drive(2'b11, 32'h11, 32'h21);
        drive(2'b11, 32'h12, 32'h22);
        expect_stream("t2", 32'h11, 32'h12, 32'h21, 32'h22, -1, 0);

        // Test 3: stall 3 cycles on the second word.
        do_start();
        drive(2'b11, 32'h11, 32'h21);
        drive(2'b11, 32'h12, 32'h22);
        expect_stream("t3", 32'h11, 32'h12, 32'h21, 32'h22, 1, 3);

        // Test 4: staggered rows within column 0.
        do_start();
        drive(2'b01, 32'h51, 32'h0);
        drive(2'b00, 32'h0, 32'h0);
        drive(2'b10, 32'h0, 32'h61);
        drive(2'b00, 32'h0, 32'h0);
        check_eq("t4_busy", {31'd0, busy_o}, 32'd1);
        drive(2'b11, 32'h52, 32'h62);
        expect_stream("t4", 32'h51, 32'h52, 32'h61, 32'h62, -1, 0);

        // Test 5: duplicate row-0 capture keeps first value and flags overflow.
        do_start();
        drive(2'b01, 32'hAA, 32'h0);
        drive(2'b01, 32'hBB, 32'h0);
        check_eq("t5_ovf", {31'd0, overflow_o}, 32'd1);
        drive(2'b10, 32'h0, 32'h21);
        drive(2'b11, 32'h12, 32'h22);
        expect_stream("t5", 32'hAA, 32'h12, 32'h21, 32'h22, -1, 0);
        check_eq("t5_ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Test 6: valids while idle are ignored; start clears overflow.
        drive(2'b11, 32'hDEAD, 32'hBEEF);
        drive(2'b11, 32'hDEAD, 32'hBEEF);
        check_eq("t6_idle", {31'd0, busy_o}, 32'd0);
        do_start();
        check_eq("t6_ovf_clr", {31'd0, overflow_o}, 32'd0);
        drive(2'b11, 32'h31, 32'h41);
        drive(2'b11, 32'h32, 32'h42);
        expect_stream("t6", 32'h31, 32'h32, 32'h41, 32'h42, -1, 0);

        // Test 1: reset while streaming.
        do_start();
        drive(2'b11, 32'h71, 32'h81);
        drive(2'b11, 32'h72, 32'h82);
        out_ready_i = 1'b0;
        wait_valid();
        rst_i = 1'b1;
        #1;
        check_eq("t1_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("t1_busy", {31'd0, busy_o}, 32'd0);
        check_eq("t1_data", out_data_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("t1_stay_idle", {31'd0, busy_o}, 32'd0);
        check_eq("t1_no_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("t1_no_done", {31'd0, done_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
